bus_arbiter_param: RTL and testbench



---
 rtl/bus_arbiter_pkg.sv | 29 ++
 rtl/bus_arbiter_param_if.sv | 38 +++
 rtl/arbiter_index_fifo.sv | 57 +++++
 rtl/bus_arbiter_param.sv | 224 ++++++++++++++++++++++
 tb/tb_bus_arbiter_param.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_arbiter_pkg.sv
// rtl/bus_arbiter_pkg.sv - state encoding and width helper shared by the bus arbiter files
package bus_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE            = 3'd0,
    GRANT           = 3'd1,
    WAIT_BEGIN      = 3'd2,
    SERVICING       = 3'd3,
    BUS_ERROR       = 3'd4,
    END_TRANSACTION = 3'd5,
    REMOVE          = 3'd6,
    INIT_BUS_ERROR  = 3'd7
  } arb_state_e;

  // Bits needed to index 'value' entries; never less than one bit.
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result++;
      remaining = remaining >> 1;
    end
    if (result == 0) result = 1;
    return result;
  endfunction

endpackage

// File: rtl/bus_arbiter_param_if.sv
// rtl/bus_arbiter_param_if.sv - request/grant and bus control bundle between masters and the arbiter
interface bus_arbiter_param_if import bus_arbiter_pkg::*; #(
  parameter int NR_MASTERS = 32
);

  localparam int IDX_W = clog2(NR_MASTERS);

  logic [NR_MASTERS-1:0] busRequests;
  logic [NR_MASTERS-1:0] busGrants;
  logic [IDX_W-1:0]      grantIndex;
  logic [IDX_W:0]        queueCount;
  logic                  busErrorOut;
  logic                  endTransactionOut;
  logic                  busIdle;
  logic                  snoopableBurst;
  logic                  beginTransactionIn;
  logic                  endTransactionIn;
  logic                  dataValidIn;
  logic [1:0]            addressDataIn;
  logic [7:0]            burstSizeIn;

  // Bus-side view: requesters and the transaction signalling.
  modport master (
    output busRequests, beginTransactionIn, endTransactionIn, dataValidIn,
           addressDataIn, burstSizeIn,
    input  busGrants, grantIndex, queueCount, busErrorOut, endTransactionOut,
           busIdle, snoopableBurst
  );

  // Arbiter-side view.
  modport slave (
    input  busRequests, beginTransactionIn, endTransactionIn, dataValidIn,
           addressDataIn, burstSizeIn,
    output busGrants, grantIndex, queueCount, busErrorOut, endTransactionOut,
           busIdle, snoopableBurst
  );

endinterface

// File: rtl/arbiter_index_fifo.sv
// rtl/arbiter_index_fifo.sv - register FIFO of master indices with combinational head
module arbiter_index_fifo import bus_arbiter_pkg::*; #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 5
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_push_data,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_head,
  output logic [clog2(DEPTH):0]  o_count,
  output logic                   o_empty
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = i_push && (r_count != FULL_CNT);
  assign w_do_pop  = i_pop && (r_count != '0);

  // Entry storage; validity is tracked by the count, so no reset is needed.
  always_ff @(posedge clock) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  // Wrap-around pointers and occupancy; simultaneous push and pop keep the count.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/bus_arbiter_param.sv
// rtl/bus_arbiter_param.sv - first-come-first-served bus arbiter; BUS_ARBITER_STATS_EN adds grant/error/withdraw counters
module bus_arbiter_param import bus_arbiter_pkg::*; #(
  parameter int NR_MASTERS       = 32,
  parameter int TIMEOUT_BITS     = 16,
  parameter int SNOOP_BURST_SIZE = 7
) (
  input  logic               clock,
  input  logic               reset,
  bus_arbiter_param_if.slave bus
`ifdef BUS_ARBITER_STATS_EN
  ,
  input  logic               statsClear,
  output logic [31:0]        grantCount,
  output logic [15:0]        errorCount,
  output logic [15:0]        withdrawCount
`endif
);

  localparam int IDX_W = clog2(NR_MASTERS);
  localparam int CNT_W = IDX_W + 1;

  arb_state_e              r_state;
  arb_state_e              w_state_nxt;
  logic [NR_MASTERS-1:0]   r_queued;
  logic [TIMEOUT_BITS-1:0] r_watchdog;
  logic                    r_active;
  logic [NR_MASTERS-1:0]   r_grants;
  logic [IDX_W-1:0]        r_grant_index;
  logic                    r_bus_error;
  logic                    r_end_out;
  logic                    r_bus_idle;
  logic                    r_snoop;

  logic [NR_MASTERS-1:0]   w_outstanding;
  logic                    w_push;
  logic [IDX_W-1:0]        w_push_idx;
  logic                    w_pop;
  logic [IDX_W-1:0]        w_head;
  logic [CNT_W-1:0]        w_count;
  logic                    w_empty;
  logic [NR_MASTERS-1:0]   w_set_mask;
  logic [NR_MASTERS-1:0]   w_clr_mask;
  logic [NR_MASTERS-1:0]   w_grant_mask;
  logic                    w_expired;
  logic                    w_head_req;
  logic                    w_issue_grant;
  logic                    w_withdraw;
  logic                    w_wd_reload;
  logic                    w_active_set;
  logic                    w_active_nxt;
  logic                    w_error_entry;

  assign w_outstanding = bus.busRequests & ~r_queued;
  assign w_expired     = (r_watchdog == '0);
  assign w_head_req    = bus.busRequests[w_head];

  arbiter_index_fifo #(
    .DEPTH (NR_MASTERS),
    .WIDTH (IDX_W)
  ) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .i_push      (w_push),
    .i_push_data (w_push_idx),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_count     (w_count),
    .o_empty     (w_empty)
  );

  // Pick the highest-index outstanding master and build the queued/grant masks.
  always_comb begin
    w_push       = 1'b0;
    w_push_idx   = '0;
    w_set_mask   = '0;
    w_clr_mask   = '0;
    w_grant_mask = '0;
    for (int i = 0; i < NR_MASTERS; i++) begin
      if (w_outstanding[i]) begin
        w_push     = 1'b1;
        w_push_idx = IDX_W'(i);
      end
    end
    for (int i = 0; i < NR_MASTERS; i++) begin
      w_set_mask[i]   = w_push && (w_push_idx == IDX_W'(i));
      w_clr_mask[i]   = w_pop && (w_head == IDX_W'(i));
      w_grant_mask[i] = w_issue_grant && (w_head == IDX_W'(i));
    end
  end

  // Next-state logic, grant/pop strobes and watchdog reload requests.
  always_comb begin
    w_state_nxt   = r_state;
    w_pop         = 1'b0;
    w_issue_grant = 1'b0;
    w_withdraw    = 1'b0;
    w_wd_reload   = 1'b0;
    w_active_set  = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.beginTransactionIn) w_state_nxt = INIT_BUS_ERROR;
        else if (!w_empty)          w_state_nxt = GRANT;
      end
      GRANT: begin
        if (bus.beginTransactionIn) begin
          w_state_nxt = INIT_BUS_ERROR;
        end else if (!w_head_req) begin
          w_state_nxt = REMOVE;
          w_withdraw  = 1'b1;
        end else begin
          w_state_nxt   = WAIT_BEGIN;
          w_issue_grant = 1'b1;
        end
      end
      WAIT_BEGIN: begin
        if (bus.beginTransactionIn) begin
          w_state_nxt  = SERVICING;
          w_active_set = 1'b1;
          w_wd_reload  = 1'b1;
        end else if (w_expired) begin
          w_state_nxt = REMOVE;
        end
      end
      SERVICING: begin
        if (bus.dataValidIn) w_wd_reload = 1'b1;
        if (bus.beginTransactionIn || w_expired) w_state_nxt = INIT_BUS_ERROR;
        else if (bus.endTransactionIn)           w_state_nxt = REMOVE;
      end
      INIT_BUS_ERROR: begin
        w_state_nxt = bus.endTransactionIn ? IDLE : BUS_ERROR;
      end
      BUS_ERROR: begin
        if (w_expired)                             w_state_nxt = END_TRANSACTION;
        else if (bus.endTransactionIn && r_active) w_state_nxt = REMOVE;
        else if (bus.endTransactionIn)             w_state_nxt = IDLE;
      end
      END_TRANSACTION: begin
        w_state_nxt = IDLE;
      end
      REMOVE: begin
        w_pop       = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    // GRANT and INIT_BUS_ERROR never self-loop, so any transition into them is an entry.
    w_error_entry = (w_state_nxt == INIT_BUS_ERROR);
    if (w_state_nxt == GRANT || w_error_entry) w_wd_reload = 1'b1;
    // The transaction ends whenever the FSM heads back to IDLE or drops the head.
    if (w_active_set)                                    w_active_nxt = 1'b1;
    else if (w_state_nxt == IDLE || w_state_nxt == REMOVE) w_active_nxt = 1'b0;
    else                                                 w_active_nxt = r_active;
  end

  // State register, queued bitmap, watchdog and active flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= IDLE;
      r_queued   <= '0;
      r_watchdog <= '1;
      r_active   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_queued   <= (r_queued | w_set_mask) & ~w_clr_mask;
      r_active   <= w_active_nxt;
      if (w_wd_reload)          r_watchdog <= '1;
      else if (!w_expired)      r_watchdog <= r_watchdog - TIMEOUT_BITS'(1);
    end
  end

  // Registered bus outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_grants      <= '0;
      r_grant_index <= '0;
      r_bus_error   <= 1'b0;
      r_end_out     <= 1'b0;
      r_bus_idle    <= 1'b1;
      r_snoop       <= 1'b0;
    end else begin
      r_grants    <= w_grant_mask;
      if (w_issue_grant) r_grant_index <= w_head;
      r_bus_error <= (r_state == INIT_BUS_ERROR || r_state == BUS_ERROR) && !bus.endTransactionIn;
      r_end_out   <= (r_state == END_TRANSACTION);
      r_bus_idle  <= ~w_active_nxt;
      r_snoop     <= bus.beginTransactionIn && (bus.addressDataIn == 2'b00) &&
                     (bus.burstSizeIn == 8'(SNOOP_BURST_SIZE));
    end
  end

  assign bus.busGrants         = r_grants;
  assign bus.grantIndex        = r_grant_index;
  assign bus.queueCount        = w_count;
  assign bus.busErrorOut       = r_bus_error;
  assign bus.endTransactionOut = r_end_out;
  assign bus.busIdle           = r_bus_idle;
  assign bus.snoopableBurst    = r_snoop;

`ifdef BUS_ARBITER_STATS_EN
  logic [31:0] r_grant_cnt;
  logic [15:0] r_error_cnt;
  logic [15:0] r_withdraw_cnt;

  // Saturating event counters, cleared by reset or statsClear.
  always_ff @(posedge clock) begin
    if (reset || statsClear) begin
      r_grant_cnt    <= '0;
      r_error_cnt    <= '0;
      r_withdraw_cnt <= '0;
    end else begin
      if (w_issue_grant && r_grant_cnt != '1)    r_grant_cnt    <= r_grant_cnt + 32'd1;
      if (w_error_entry && r_error_cnt != '1)    r_error_cnt    <= r_error_cnt + 16'd1;
      if (w_withdraw && r_withdraw_cnt != '1)    r_withdraw_cnt <= r_withdraw_cnt + 16'd1;
    end
  end

  assign grantCount    = r_grant_cnt;
  assign errorCount    = r_error_cnt;
  assign withdrawCount = r_withdraw_cnt;
`endif

endmodule

// File: tb/tb_bus_arbiter_param.sv
// tb/tb_bus_arbiter_param.sv - directed bench for bus_arbiter_param (8 masters, 4-bit watchdog)
module tb_bus_arbiter_param;

  logic clock;
  logic reset;
  int   total;
  int   bad;

  bus_arbiter_param_if #(.NR_MASTERS(8)) bus_if ();

`ifdef BUS_ARBITER_STATS_EN
  logic        statsClear;
  logic [31:0] grantCount;
  logic [15:0] errorCount;
  logic [15:0] withdrawCount;
`endif

  bus_arbiter_param #(
    .NR_MASTERS       (8),
    .TIMEOUT_BITS     (4),
    .SNOOP_BURST_SIZE (7)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
`ifdef BUS_ARBITER_STATS_EN
    ,
    .statsClear    (statsClear),
    .grantCount    (grantCount),
    .errorCount    (errorCount),
    .withdrawCount (withdrawCount)
`endif
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_grant(output int n);
    n = -1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (bus_if.busGrants != 8'h00) begin
        n = c;
        return;
      end
    end
  endtask

  task automatic serve(input logic [7:0] drop);
    bus_if.busRequests = bus_if.busRequests & ~drop;
    bus_if.beginTransactionIn = 1'b1;
    tick();
    bus_if.beginTransactionIn = 1'b0;
    bus_if.endTransactionIn = 1'b1;
    tick();
    bus_if.endTransactionIn = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus_if.busRequests = 8'h00;
    bus_if.beginTransactionIn = 1'b0;
    bus_if.endTransactionIn = 1'b0;
    bus_if.dataValidIn = 1'b0;
    bus_if.addressDataIn = 2'b00;
    bus_if.burstSizeIn = 8'd0;
`ifdef BUS_ARBITER_STATS_EN
    statsClear = 1'b0;
`endif
    repeat (3) tick();
    total++; if (bus_if.busGrants !== 8'h00) begin bad++; $display("FAIL reset_grants got=%h want=00", bus_if.busGrants); end
    total++; if (bus_if.grantIndex !== 3'd0) begin bad++; $display("FAIL reset_index got=%0d want=0", bus_if.grantIndex); end
    total++; if (bus_if.queueCount !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", bus_if.queueCount); end
    total++; if (bus_if.busErrorOut !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", bus_if.busErrorOut); end
    total++; if (bus_if.endTransactionOut !== 1'b0) begin bad++; $display("FAIL reset_endout got=%b want=0", bus_if.endTransactionOut); end
    total++; if (bus_if.busIdle !== 1'b1) begin bad++; $display("FAIL reset_idle got=%b want=1", bus_if.busIdle); end
    total++; if (bus_if.snoopableBurst !== 1'b0) begin bad++; $display("FAIL reset_snoop got=%b want=0", bus_if.snoopableBurst); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_grant();
    int n;
    bus_if.busRequests = 8'h01;
    wait_grant(n);
    total++; if (n != 3) begin bad++; $display("FAIL single_latency got=%0d want=3", n); end
    total++; if (bus_if.busGrants !== 8'h01) begin bad++; $display("FAIL single_grant got=%h want=01", bus_if.busGrants); end
    total++; if (bus_if.grantIndex !== 3'd0) begin bad++; $display("FAIL single_index got=%0d want=0", bus_if.grantIndex); end
    tick();
    total++; if (bus_if.busGrants !== 8'h00) begin bad++; $display("FAIL single_pulse got=%h want=00", bus_if.busGrants); end
    serve(8'h01);
    total++; if (bus_if.queueCount !== 4'd0) begin bad++; $display("FAIL single_count got=%0d want=0", bus_if.queueCount); end
    total++; if (bus_if.busIdle !== 1'b1) begin bad++; $display("FAIL single_idle got=%b want=1", bus_if.busIdle); end
  endtask

  task automatic test_two_requests();
    int n;
    bus_if.busRequests = 8'h81;
    wait_grant(n);
    total++; if (bus_if.busGrants !== 8'h80) begin bad++; $display("FAIL two_first got=%h want=80", bus_if.busGrants); end
    total++; if (bus_if.grantIndex !== 3'd7) begin bad++; $display("FAIL two_index7 got=%0d want=7", bus_if.grantIndex); end
    total++; if (bus_if.queueCount !== 4'd2) begin bad++; $display("FAIL two_count2 got=%0d want=2", bus_if.queueCount); end
    serve(8'h80);
    total++; if (bus_if.queueCount !== 4'd1) begin bad++; $display("FAIL two_count1 got=%0d want=1", bus_if.queueCount); end
    wait_grant(n);
    total++; if (n != 2) begin bad++; $display("FAIL two_second_latency got=%0d want=2", n); end
    total++; if (bus_if.busGrants !== 8'h01) begin bad++; $display("FAIL two_second got=%h want=01", bus_if.busGrants); end
    total++; if (bus_if.grantIndex !== 3'd0) begin bad++; $display("FAIL two_index0 got=%0d want=0", bus_if.grantIndex); end
    serve(8'h01);
    total++; if (bus_if.queueCount !== 4'd0) begin bad++; $display("FAIL two_count0 got=%0d want=0", bus_if.queueCount); end
  endtask

  task automatic test_back_to_back();
    int n;
    bus_if.busRequests = 8'h06;
    wait_grant(n);
    total++; if (bus_if.busGrants !== 8'h04) begin bad++; $display("FAIL b2b_first got=%h want=04", bus_if.busGrants); end
    bus_if.busRequests = 8'h02;
    bus_if.beginTransactionIn = 1'b1;
    tick();
    bus_if.beginTransactionIn = 1'b0;
    bus_if.endTransactionIn = 1'b1;
    tick();
    bus_if.endTransactionIn = 1'b0;
    bus_if.busRequests = 8'h22;
    tick();
    total++; if (bus_if.queueCount !== 4'd2) begin bad++; $display("FAIL b2b_pushpop_count got=%0d want=2", bus_if.queueCount); end
    wait_grant(n);
    total++; if (bus_if.busGrants !== 8'h02) begin bad++; $display("FAIL b2b_second got=%h want=02", bus_if.busGrants); end
    serve(8'h02);
    wait_grant(n);
    total++; if (bus_if.busGrants !== 8'h20) begin bad++; $display("FAIL b2b_third got=%h want=20", bus_if.busGrants); end
    total++; if (bus_if.grantIndex !== 3'd5) begin bad++; $display("FAIL b2b_index got=%0d want=5", bus_if.grantIndex); end
    serve(8'h20);
    total++; if (bus_if.queueCount !== 4'd0) begin bad++; $display("FAIL b2b_count0 got=%0d want=0", bus_if.queueCount); end
  endtask

  task automatic test_withdraw();
    logic [7:0] seen;
    bus_if.busRequests = 8'h08;
    tick();
    seen = bus_if.busGrants;
    total++; if (bus_if.queueCount !== 4'd1) begin bad++; $display("FAIL withdraw_queued got=%0d want=1", bus_if.queueCount); end
    bus_if.busRequests = 8'h00;
    for (int i = 0; i < 3; i++) begin
      tick();
      seen = seen | bus_if.busGrants;
    end
    total++; if (seen !== 8'h00) begin bad++; $display("FAIL withdraw_nogrant got=%h want=00", seen); end
    total++; if (bus_if.queueCount !== 4'd0) begin bad++; $display("FAIL withdraw_count got=%0d want=0", bus_if.queueCount); end
`ifdef BUS_ARBITER_STATS_EN
    total++; if (withdrawCount !== 16'd1) begin bad++; $display("FAIL withdraw_stat got=%0d want=1", withdrawCount); end
    total++; if (grantCount !== 32'd6) begin bad++; $display("FAIL withdraw_grantstat got=%0d want=6", grantCount); end
    total++; if (errorCount !== 16'd0) begin bad++; $display("FAIL withdraw_errstat got=%0d want=0", errorCount); end
`endif
  endtask

  task automatic test_wait_timeout();
    int n;
    bus_if.busRequests = 8'h06;
    wait_grant(n);
    total++; if (bus_if.busGrants !== 8'h04) begin bad++; $display("FAIL timeout_first got=%h want=04", bus_if.busGrants); end
    bus_if.busRequests = 8'h02;
    wait_grant(n);
    total++; if (n != 18) begin bad++; $display("FAIL timeout_gap got=%0d want=18", n); end
    total++; if (bus_if.busGrants !== 8'h02) begin bad++; $display("FAIL timeout_next got=%h want=02", bus_if.busGrants); end
    total++; if (bus_if.queueCount !== 4'd1) begin bad++; $display("FAIL timeout_count got=%0d want=1", bus_if.queueCount); end
    serve(8'h02);
  endtask

  task automatic test_bus_error();
    int n;
    int first_err;
    bus_if.busRequests = 8'h10;
    wait_grant(n);
    bus_if.busRequests = 8'h00;
    bus_if.beginTransactionIn = 1'b1;
    tick();
    bus_if.beginTransactionIn = 1'b0;
    total++; if (bus_if.busIdle !== 1'b0) begin bad++; $display("FAIL buserr_active got=%b want=0", bus_if.busIdle); end
    first_err = -1;
    n = -1;
    for (int c = 1; c <= 60; c++) begin
      tick();
      if (bus_if.busErrorOut === 1'b1 && first_err < 0) first_err = c;
      if (bus_if.endTransactionOut === 1'b1) begin
        n = c;
        break;
      end
    end
    total++; if (first_err != 17) begin bad++; $display("FAIL buserr_err_time got=%0d want=17", first_err); end
    total++; if (n != 33) begin bad++; $display("FAIL buserr_endout_time got=%0d want=33", n); end
    total++; if (bus_if.busIdle !== 1'b1) begin bad++; $display("FAIL buserr_idle got=%b want=1", bus_if.busIdle); end
    total++; if (bus_if.busErrorOut !== 1'b0) begin bad++; $display("FAIL buserr_errclr got=%b want=0", bus_if.busErrorOut); end
    tick();
    total++; if (bus_if.endTransactionOut !== 1'b0) begin bad++; $display("FAIL buserr_endpulse got=%b want=0", bus_if.endTransactionOut); end
    repeat (2) tick();
    total++; if (bus_if.queueCount !== 4'd0) begin bad++; $display("FAIL buserr_count got=%0d want=0", bus_if.queueCount); end
`ifdef BUS_ARBITER_STATS_EN
    total++; if (grantCount !== 32'd9) begin bad++; $display("FAIL buserr_grantstat got=%0d want=9", grantCount); end
    total++; if (errorCount !== 16'd1) begin bad++; $display("FAIL buserr_errstat got=%0d want=1", errorCount); end
    total++; if (withdrawCount !== 16'd2) begin bad++; $display("FAIL buserr_wdstat got=%0d want=2", withdrawCount); end
`endif
  endtask

  task automatic test_snoop();
    int n;
    logic [7:0] burst_tab [3];
    logic [1:0] addr_tab [3];
    logic       want_tab [3];
    burst_tab = '{8'd7, 8'd3, 8'd7};
    addr_tab  = '{2'd0, 2'd0, 2'd1};
    want_tab  = '{1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      bus_if.busRequests = 8'h20;
      wait_grant(n);
      bus_if.busRequests = 8'h00;
      bus_if.addressDataIn = addr_tab[i];
      bus_if.burstSizeIn = burst_tab[i];
      bus_if.beginTransactionIn = 1'b1;
      tick();
      total++; if (bus_if.snoopableBurst !== want_tab[i]) begin bad++; $display("FAIL snoop_%0d got=%b want=%b", i, bus_if.snoopableBurst, want_tab[i]); end
      bus_if.beginTransactionIn = 1'b0;
      bus_if.endTransactionIn = 1'b1;
      tick();
      bus_if.endTransactionIn = 1'b0;
      tick();
    end
    bus_if.addressDataIn = 2'd0;
    bus_if.burstSizeIn = 8'd0;
`ifdef BUS_ARBITER_STATS_EN
    total++; if (grantCount !== 32'd12) begin bad++; $display("FAIL snoop_grantstat got=%0d want=12", grantCount); end
    statsClear = 1'b1;
    tick();
    statsClear = 1'b0;
    total++; if (grantCount !== 32'd0 || errorCount !== 16'd0 || withdrawCount !== 16'd0) begin
      bad++; $display("FAIL stats_clear got=%0d/%0d/%0d want=0/0/0", grantCount, errorCount, withdrawCount);
    end
`endif
  endtask

  task automatic test_reset_mid();
    int n;
    logic seen_end;
    logic [7:0] seen_grant;
    bus_if.busRequests = 8'h40;
    wait_grant(n);
    total++; if (bus_if.grantIndex !== 3'd6) begin bad++; $display("FAIL midrst_index got=%0d want=6", bus_if.grantIndex); end
    bus_if.beginTransactionIn = 1'b1;
    tick();
    bus_if.beginTransactionIn = 1'b0;
    total++; if (bus_if.busIdle !== 1'b0) begin bad++; $display("FAIL midrst_active got=%b want=0", bus_if.busIdle); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus_if.busRequests = 8'h00;
    total++; if (bus_if.busIdle !== 1'b1) begin bad++; $display("FAIL midrst_idle got=%b want=1", bus_if.busIdle); end
    total++; if (bus_if.queueCount !== 4'd0) begin bad++; $display("FAIL midrst_count got=%0d want=0", bus_if.queueCount); end
    total++; if (bus_if.grantIndex !== 3'd0) begin bad++; $display("FAIL midrst_index0 got=%0d want=0", bus_if.grantIndex); end
    seen_end = 1'b0;
    seen_grant = 8'h00;
    for (int i = 0; i < 20; i++) begin
      tick();
      seen_end = seen_end | bus_if.endTransactionOut;
      seen_grant = seen_grant | bus_if.busGrants;
    end
    total++; if (seen_end !== 1'b0) begin bad++; $display("FAIL midrst_noend got=%b want=0", seen_end); end
    total++; if (seen_grant !== 8'h00) begin bad++; $display("FAIL midrst_nogrant got=%h want=00", seen_grant); end
`ifdef BUS_ARBITER_STATS_EN
    total++; if (grantCount !== 32'd0) begin bad++; $display("FAIL midrst_grantstat got=%0d want=0", grantCount); end
`endif
  endtask

  initial begin
    clock = 1'b0;
    total = 0;
    bad = 0;
    test_reset();
    test_single_grant();
    test_two_requests();
    test_back_to_back();
    test_withdraw();
    test_wait_timeout();
    test_bus_error();
    test_snoop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
